// File: rtl/dcr_memory.sv
// MEM pipeline stage: synchronous data RAM with a small MMIO window (cycle counter, output port),
// load/ALU result selection for EXE forwarding, and the MEM->WB pipeline register.
module dcr_memory #(
    parameter int                    ADDR_WIDTH = 8,
    parameter logic [ADDR_WIDTH-1:0] CNT_ADDR   = 8'hFE,
    parameter logic [ADDR_WIDTH-1:0] PORT_ADDR  = 8'hFF
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  clken,
    input  logic [ADDR_WIDTH-1:0] MemAddrInEXE,
    input  logic [31:0]           StoreDataInEXE,
    input  logic                  MemWriteInEXE,
    input  logic                  MemToRegInEXE,
    input  logic                  RegWriteInEXE,
    input  logic [4:0]            WriteRegInEXE,
    input  logic [31:0]           ALUResultInMEM,
    output logic [31:0]           MEMBypassDataOutEXE,
    output logic [4:0]            MEMWriteRegOutID,
    output logic                  MEMRegWriteOutID,
    output logic [31:0]           WBDataOutWB,
    output logic [4:0]            WBWriteRegOutWB,
    output logic                  WBRegWriteOutWB,
    output logic [31:0]           PortOut
);

    localparam int DEPTH = 2 ** ADDR_WIDTH;

    logic [31:0] ram [DEPTH];
    logic [31:0] ram_q;
    logic [31:0] mmio_q;
    logic [31:0] cycle_cnt;
    logic        is_cnt_exe, is_port_exe;
    logic        is_cnt, is_port;
    logic        mem_to_reg;
    logic [31:0] load_data;
    logic [31:0] result;

    assign is_cnt_exe  = (MemAddrInEXE == CNT_ADDR);
    assign is_port_exe = (MemAddrInEXE == PORT_ADDR);

    // NOTE: the RAM array has no reset so it maps onto block RAM; writes are gated by rst instead.
    always_ff @(posedge clk) begin
        if (!rst && clken && MemWriteInEXE && !is_cnt_exe && !is_port_exe)
            ram[MemAddrInEXE] <= StoreDataInEXE;
    end

    // Free-running cycle counter; ignores stalls.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) cycle_cnt <= '0;
        else     cycle_cnt <= cycle_cnt + 32'd1;
    end

    // EXE->MEM: read captures (old values, so read-first), port write and MEM control regs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ram_q            <= '0;
            mmio_q           <= '0;
            PortOut          <= '0;
            is_cnt           <= 1'b0;
            is_port          <= 1'b0;
            mem_to_reg       <= 1'b0;
            MEMRegWriteOutID <= 1'b0;
            MEMWriteRegOutID <= '0;
        end else if (clken) begin
            ram_q            <= ram[MemAddrInEXE];
            mmio_q           <= is_cnt_exe ? cycle_cnt : PortOut;
            is_cnt           <= is_cnt_exe;
            is_port          <= is_port_exe;
            mem_to_reg       <= MemToRegInEXE;
            MEMRegWriteOutID <= RegWriteInEXE;
            MEMWriteRegOutID <= WriteRegInEXE;
            if (MemWriteInEXE && is_port_exe)
                PortOut <= StoreDataInEXE;
        end
    end

    always_comb begin
        load_data = (is_cnt || is_port) ? mmio_q : ram_q;
        result    = mem_to_reg ? load_data : ALUResultInMEM;
    end

    assign MEMBypassDataOutEXE = result;

    // MEM->WB pipeline register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            WBDataOutWB     <= '0;
            WBWriteRegOutWB <= '0;
            WBRegWriteOutWB <= 1'b0;
        end else if (clken) begin
            WBDataOutWB     <= result;
            WBWriteRegOutWB <= MEMWriteRegOutID;
            WBRegWriteOutWB <= MEMRegWriteOutID;
        end
    end

endmodule

// File: tb/tb_dcr_memory.sv
// Self-checking bench for dcr_memory: directed scenarios plus random traffic against a
// transaction-level model (word array, port, counter, two-slot pipeline).
module tb_dcr_memory;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        clken = 1'b0;
    logic [7:0]  MemAddrInEXE = '0;
    logic [31:0] StoreDataInEXE = '0;
    logic        MemWriteInEXE = 1'b0;
    logic        MemToRegInEXE = 1'b0;
    logic        RegWriteInEXE = 1'b0;
    logic [4:0]  WriteRegInEXE = '0;
    logic [31:0] ALUResultInMEM = '0;
    logic [31:0] MEMBypassDataOutEXE;
    logic [4:0]  MEMWriteRegOutID;
    logic        MEMRegWriteOutID;
    logic [31:0] WBDataOutWB;
    logic [4:0]  WBWriteRegOutWB;
    logic        WBRegWriteOutWB;
    logic [31:0] PortOut;

    dcr_memory dut (
        .clk                 (clk),
        .rst                 (rst),
        .clken               (clken),
        .MemAddrInEXE        (MemAddrInEXE),
        .StoreDataInEXE      (StoreDataInEXE),
        .MemWriteInEXE       (MemWriteInEXE),
        .MemToRegInEXE       (MemToRegInEXE),
        .RegWriteInEXE       (RegWriteInEXE),
        .WriteRegInEXE       (WriteRegInEXE),
        .ALUResultInMEM      (ALUResultInMEM),
        .MEMBypassDataOutEXE (MEMBypassDataOutEXE),
        .MEMWriteRegOutID    (MEMWriteRegOutID),
        .MEMRegWriteOutID    (MEMRegWriteOutID),
        .WBDataOutWB         (WBDataOutWB),
        .WBWriteRegOutWB     (WBWriteRegOutWB),
        .WBRegWriteOutWB     (WBRegWriteOutWB),
        .PortOut             (PortOut)
    );

    always #5 clk = ~clk;

    int unsigned n_vec = 0;
    int unsigned n_err = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    // Reference model: memory image, port, counter, and the instruction sitting in MEM / WB.
    logic [31:0] ref_mem [256];
    logic [31:0] ref_port, ref_cnt;
    logic        m_load, m_rw;
    logic [4:0]  m_wr;
    logic [31:0] m_ld, m_alu;
    logic [31:0] w_data;
    logic [4:0]  w_wr;
    logic        w_rw;

    function automatic logic [31:0] mem_result();
        return m_load ? m_ld : m_alu;
    endfunction

    task automatic model_reset();
        ref_port = '0; ref_cnt = '0;
        m_load = 1'b0; m_rw = 1'b0; m_wr = '0; m_ld = '0; m_alu = '0;
        w_data = '0; w_wr = '0; w_rw = 1'b0;
        ALUResultInMEM = '0;
    endtask

    task automatic check_all(input string where);
        check({where, ".bypass"}, MEMBypassDataOutEXE, mem_result());
        check({where, ".mem_wr"}, 32'(MEMWriteRegOutID), 32'(m_wr));
        check({where, ".mem_rw"}, 32'(MEMRegWriteOutID), 32'(m_rw));
        check({where, ".wb_data"}, WBDataOutWB, w_data);
        check({where, ".wb_wr"}, 32'(WBWriteRegOutWB), 32'(w_wr));
        check({where, ".wb_rw"}, 32'(WBRegWriteOutWB), 32'(w_rw));
        check({where, ".port"}, PortOut, ref_port);
    endtask

    // One clock: present an instruction to EXE, advance the model, then compare.
    task automatic step(input string where, input logic ce, input logic we, input logic ld,
                        input logic rw, input logic [7:0] addr, input logic [31:0] sd,
                        input logic [4:0] wr, input logic [31:0] alu_next);
        logic [31:0] ldval;
        clken = ce; MemWriteInEXE = we; MemToRegInEXE = ld; RegWriteInEXE = rw;
        MemAddrInEXE = addr; StoreDataInEXE = sd; WriteRegInEXE = wr;
        if (ce) begin
            w_data = mem_result(); w_wr = m_wr; w_rw = m_rw;
            if (addr == 8'hFE)      ldval = ref_cnt;
            else if (addr == 8'hFF) ldval = ref_port;
            else                    ldval = ref_mem[addr];
            if (we) begin
                if (addr == 8'hFF)      ref_port = sd;
                else if (addr != 8'hFE) ref_mem[addr] = sd;
            end
            m_load = ld; m_rw = rw; m_wr = wr; m_ld = ldval; m_alu = alu_next;
        end
        @(posedge clk);
        ref_cnt = ref_cnt + 32'd1;
        #1;
        if (ce) ALUResultInMEM = alu_next;
        #1;
        check_all(where);
    endtask

    initial begin
        logic [7:0]  a;
        logic [31:0] saved_port;
        model_reset();
        #1;
        check_all("reset");
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        for (int i = 0; i < 32; i++)
            step("init", 1'b1, 1'b1, 1'b0, 1'b0, 8'(i), $urandom, 5'd0, 32'd0);

        // Store then dependent load, then WB one cycle later.
        step("st10", 1'b1, 1'b1, 1'b0, 1'b0, 8'h10, 32'hDEADBEEF, 5'd0, 32'h0);
        step("ld10", 1'b1, 1'b0, 1'b1, 1'b1, 8'h10, 32'h0, 5'd3, 32'h1234);
        check("ld10_value", MEMBypassDataOutEXE, 32'hDEADBEEF);
        step("nop1", 1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 32'h0, 5'd0, 32'h0);
        check("ld10_wb", WBDataOutWB, 32'hDEADBEEF);
        check("ld10_wb_wr", 32'(WBWriteRegOutWB), 32'd3);

        // Read-first on a same-edge load/store.
        step("st20a", 1'b1, 1'b1, 1'b0, 1'b0, 8'h20, 32'h11111111, 5'd0, 32'h0);
        step("rmw20", 1'b1, 1'b1, 1'b1, 1'b1, 8'h20, 32'h22222222, 5'd4, 32'h0);
        check("read_first_old", MEMBypassDataOutEXE, 32'h11111111);
        step("ld20", 1'b1, 1'b0, 1'b1, 1'b1, 8'h20, 32'h0, 5'd4, 32'h0);
        check("read_first_new", MEMBypassDataOutEXE, 32'h22222222);

        // Non-load passes the ALU result through.
        step("alu", 1'b1, 1'b0, 1'b0, 1'b1, 8'h33, 32'h0, 5'd7, 32'h42);
        check("alu_bypass", MEMBypassDataOutEXE, 32'h42);
        step("nop2", 1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 32'h0, 5'd0, 32'h0);
        check("alu_wb", WBDataOutWB, 32'h42);

        // MMIO: port write, ignored counter write, counter read.
        step("stport", 1'b1, 1'b1, 1'b0, 1'b0, 8'hFF, 32'hA5, 5'd0, 32'h0);
        check("port_a5", PortOut, 32'hA5);
        step("stcnt", 1'b1, 1'b1, 1'b0, 1'b0, 8'hFE, 32'hFFFF0000, 5'd0, 32'h0);
        step("ldcnt", 1'b1, 1'b0, 1'b1, 1'b1, 8'hFE, 32'h0, 5'd9, 32'h0);
        step("ldport", 1'b1, 1'b0, 1'b1, 1'b1, 8'hFF, 32'h0, 5'd9, 32'h0);

        // Three stalled cycles with stores pending.
        saved_port = ref_port;
        step("stall0", 1'b0, 1'b1, 1'b0, 1'b1, 8'hFF, 32'h5A5A5A5A, 5'd1, 32'h0);
        step("stall1", 1'b0, 1'b1, 1'b0, 1'b1, 8'h10, 32'h5A5A5A5A, 5'd1, 32'h0);
        step("stall2", 1'b0, 1'b1, 1'b0, 1'b1, 8'h20, 32'h5A5A5A5A, 5'd1, 32'h0);
        check("stall_port", PortOut, saved_port);
        step("ldcnt2", 1'b1, 1'b0, 1'b1, 1'b1, 8'hFE, 32'h0, 5'd2, 32'h0);
        step("ld10b", 1'b1, 1'b0, 1'b1, 1'b1, 8'h10, 32'h0, 5'd2, 32'h0);
        check("stall_ram", MEMBypassDataOutEXE, 32'hDEADBEEF);

        // Random traffic over a small address window plus MMIO.
        for (int i = 0; i < 400; i++) begin
            case ($urandom_range(0, 9))
                0:       a = 8'hFE;
                1:       a = 8'hFF;
                default: a = 8'($urandom_range(0, 31));
            endcase
            step("rand", $urandom_range(0, 4) != 0, 1'($urandom), 1'($urandom), 1'($urandom),
                 a, $urandom, 5'($urandom), $urandom);
        end

        // Mid-stream reset with a store pending on the next edge.
        clken = 1'b1; MemWriteInEXE = 1'b1; MemAddrInEXE = 8'h05;
        StoreDataInEXE = 32'hCAFEF00D; MemToRegInEXE = 1'b0;
        #2 rst = 1'b1;
        model_reset();
        #1;
        check_all("async_rst");
        check("async_rst_wb", WBDataOutWB, 32'h0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        step("ldcnt0", 1'b1, 1'b0, 1'b1, 1'b1, 8'hFE, 32'h0, 5'd6, 32'h0);
        check("cnt_restart", MEMBypassDataOutEXE, 32'h0);
        step("ld05", 1'b1, 1'b0, 1'b1, 1'b1, 8'h05, 32'h0, 5'd6, 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got no finish, expected finish");
        $fatal(1, "timeout");
    end

endmodule
